mux_sel_controller: RTL and testbench

- Sequences the 2:1 timer-source mux in the microwave datapath.
- Drives `sel` to choose the time-entry pulse path (DelayIn, sel=0) or the 1 Hz countdown path (DivideBy100, sel=1).
- Emits one clean single-cycle `tick_out` per rising edge of the selected source, with guard cycles around every switchover so the countdown timer never sees a spurious edge.
- Sits between the keypad/door logic and the seconds countdown counter; also drives the magnetron enable.

---
 rtl/microwave_pkg.sv | 25 ++
 rtl/mux_sel_controller_if.sv | 37 +++
 rtl/mux_sel_controller_edge_gate.sv | 53 +++++
 rtl/mux_sel_controller.sv | 214 +++++++++++++++++++++
 tb/tb_mux_sel_controller.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg: shared definitions for the microwave timer-source sequencing.
//   state_t   : controller state encoding (IDLE, ARM, COOK, PAUSE, DONE)
//   SEL_DELAY : mux select value for the DelayIn (time-entry pulse) path
//   SEL_DIV   : mux select value for the DivideBy100 (1 Hz) path
//   sel_for() : mux select implied by a controller state
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic SEL_DELAY = 1'b0;
  localparam logic SEL_DIV   = 1'b1;

  // The countdown source is selected from the moment the oven is armed until
  // it either finishes or is cleared; everywhere else the entry path is live.
  function automatic logic sel_for(input state_t s);
    return (s == ARM || s == COOK || s == PAUSE) ? SEL_DIV : SEL_DELAY;
  endfunction

endpackage

// File: rtl/mux_sel_controller_if.sv
// mux_sel_controller_if: bundles the keypad/door/timer inputs, the two timer
// sources and the controller outputs of mux_sel_controller.
//   startn/stopn/clearn : active-low synchronized buttons
//   door_closed         : 1 = door closed
//   timer_zero          : countdown counter reads 0
//   delay_in/divide_in  : DelayIn and DivideBy100 timer sources
//   sel, tick_out       : mux select and one-cycle tick towards the counter
//   load_en, mag_on     : timer load mode, magnetron enable
//   done, fault         : cook complete, watchdog fault
// Modports: master = environment driving the controller, slave = controller.
interface mux_sel_controller_if;

  logic startn;
  logic stopn;
  logic clearn;
  logic door_closed;
  logic timer_zero;
  logic delay_in;
  logic divide_in;
  logic sel;
  logic tick_out;
  logic load_en;
  logic mag_on;
  logic done;
  logic fault;

  modport master (
    output startn, stopn, clearn, door_closed, timer_zero, delay_in, divide_in,
    input  sel, tick_out, load_en, mag_on, done, fault
  );

  modport slave (
    input  startn, stopn, clearn, door_closed, timer_zero, delay_in, divide_in,
    output sel, tick_out, load_en, mag_on, done, fault
  );

endinterface

// File: rtl/mux_sel_controller_edge_gate.sv
// edge_gate: rising-edge detector for the currently selected timer source with
// a switchover guard.
//   clk, rst_n  : clock, asynchronous active-low reset
//   src         : source value as selected for the coming cycle
//   reload      : source changes (or guard must be re-applied) at this edge
//   en          : allow a pulse to be issued at this edge
//   guard_len   : number of cycles pulses are suppressed after a reload
//   pulse       : one-cycle pulse, one clock after the sampled rising edge
//   guard_idle  : guard counter has run out
module edge_gate #(
  parameter int GUARD_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               src,
  input  logic               reload,
  input  logic               en,
  input  logic [GUARD_W-1:0] guard_len,
  output logic               pulse,
  output logic               guard_idle
);

  logic               hist_p0;
  logic [GUARD_W-1:0] guard_p0;
  logic               pulse_p0;

  // History resets high so a source already high at reset release is not an
  // edge. On reload the history takes the new source's present level, so the
  // switchover itself never looks like an edge; edges seen while the guard is
  // running update the history and are therefore dropped, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_p0  <= 1'b1;
      guard_p0 <= '0;
      pulse_p0 <= 1'b0;
    end else begin
      hist_p0 <= src;
      if (reload) begin
        guard_p0 <= guard_len;
        pulse_p0 <= 1'b0;
      end else begin
        pulse_p0 <= en & src & ~hist_p0 & (guard_p0 == '0);
        if (guard_p0 != '0) begin
          guard_p0 <= guard_p0 - 1'b1;
        end
      end
    end
  end

  assign pulse      = pulse_p0;
  assign guard_idle = (guard_p0 == '0);

endmodule

// File: rtl/mux_sel_controller.sv
// mux_sel_controller: sequences the 2:1 timer-source mux of the microwave
// datapath and drives the magnetron enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mux_sel_controller_if.slave (buttons, door, timer_zero,
//                sources in; sel, tick_out, load_en, mag_on, done, fault out)
// Parameters: GUARD_CYCLES (1..15) tick suppression after a switchover,
//   DONE_CYCLES (1..255) length of the done indication, WDOG_CYCLES cycles
//   without a divide_in edge tolerated while cooking.
// Build option: define TICK_WATCHDOG_EN to build the source-loss watchdog;
//   without it fault is tied low and loss of divide_in is not detected.
module mux_sel_controller
  import microwave_pkg::*;
#(
  parameter int GUARD_CYCLES = 4,
  parameter int DONE_CYCLES  = 8,
  parameter int WDOG_CYCLES  = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_sel_controller_if.slave   bus
);

  localparam int GUARD_W = 4;
  localparam int DONE_W  = 8;

  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 15) begin : g_guard_range
    $error("GUARD_CYCLES must be within 1..15");
  end
  if (DONE_CYCLES < 1 || DONE_CYCLES > 255) begin : g_done_range
    $error("DONE_CYCLES must be within 1..255");
  end
  if (WDOG_CYCLES < 2) begin : g_wdog_range
    $error("WDOG_CYCLES must be at least 2");
  end

  state_t              state_q;
  state_t              state_nxt;
  logic                start_p0;
  logic                stop_p0;
  logic                clear_p0;
  logic                start_press;
  logic                stop_press;
  logic                clear_press;
  logic [DONE_W-1:0]   done_cnt_q;
  logic                sel_cur;
  logic                sel_nxt;
  logic                gate_src;
  logic                gate_reload;
  logic                gate_en;
  logic                gate_pulse;
  logic                guard_idle;
  logic                start_ok;
  logic                wdog_trip;

  // Button level history; a press is the high-to-low step against it, so a
  // button held low counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_p0 <= 1'b1;
      stop_p0  <= 1'b1;
      clear_p0 <= 1'b1;
    end else begin
      start_p0 <= bus.startn;
      stop_p0  <= bus.stopn;
      clear_p0 <= bus.clearn;
    end
  end

  assign start_press = start_p0 & ~bus.startn;
  assign stop_press  = stop_p0  & ~bus.stopn;
  assign clear_press = clear_p0 & ~bus.clearn;

`ifdef TICK_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic            div_p0;
  logic            div_rise;
  logic [WD_W-1:0] wdog_q;
  logic            fault_q;
  logic            fault_nxt;

  assign div_rise  = bus.divide_in & ~div_p0;
  assign wdog_trip = (state_q == COOK) && !div_rise &&
                     (wdog_q == WD_W'(WDOG_CYCLES - 1));
  assign start_ok  = ~fault_q;

  // Counts cook cycles since the last divide_in rise; held at 0 elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_p0  <= 1'b1;
      wdog_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      div_p0  <= bus.divide_in;
      fault_q <= fault_nxt;
      if (state_q != COOK || div_rise) begin
        wdog_q <= '0;
      end else if (!wdog_trip) begin
        wdog_q <= wdog_q + 1'b1;
      end
    end
  end

  always_comb begin
    fault_nxt = fault_q;
    if (clear_press) begin
      fault_nxt = 1'b0;
    end else if (wdog_trip && state_nxt == PAUSE) begin
      fault_nxt = 1'b1;
    end
  end

  assign bus.fault = fault_q;
`else
  assign wdog_trip = 1'b0;
  assign start_ok  = 1'b1;
  assign bus.fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Within each state a clear press wins over everything; in COOK a reached
  // zero wins over door/stop so a finished cook always reports DONE.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE: begin
        if (!clear_press && start_press && start_ok &&
            bus.door_closed && !bus.timer_zero) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (clear_press) begin
          state_nxt = IDLE;
        end else if (stop_press || !bus.door_closed) begin
          state_nxt = PAUSE;
        end else if (guard_idle) begin
          state_nxt = COOK;
        end
      end
      COOK: begin
        if (clear_press) begin
          state_nxt = IDLE;
        end else if (bus.timer_zero) begin
          state_nxt = DONE;
        end else if (stop_press || !bus.door_closed || wdog_trip) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (clear_press) begin
          state_nxt = IDLE;
        end else if (start_press && start_ok && bus.door_closed) begin
          state_nxt = ARM;
        end
      end
      DONE: begin
        if (clear_press || done_cnt_q == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Loaded on DONE entry so the indication lasts exactly DONE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
    end else if (state_nxt == DONE && state_q != DONE) begin
      done_cnt_q <= DONE_W'(DONE_CYCLES - 1);
    end else if (state_q == DONE && done_cnt_q != '0) begin
      done_cnt_q <= done_cnt_q - 1'b1;
    end
  end

  // The gate is fed the source that will be selected after this edge; every
  // select change and every (re)arm restarts the guard.
  assign sel_cur     = sel_for(state_q);
  assign sel_nxt     = sel_for(state_nxt);
  assign gate_src    = (sel_nxt == SEL_DIV) ? bus.divide_in : bus.delay_in;
  assign gate_reload = (sel_nxt != sel_cur) ||
                       (state_nxt == ARM && state_q != ARM);
  assign gate_en     = (state_nxt != PAUSE);

  edge_gate #(
    .GUARD_W (GUARD_W)
  ) u_edge_gate (
    .clk        (clk),
    .rst_n      (rst_n),
    .src        (gate_src),
    .reload     (gate_reload),
    .en         (gate_en),
    .guard_len  (GUARD_W'(GUARD_CYCLES)),
    .pulse      (gate_pulse),
    .guard_idle (guard_idle)
  );

  // Outputs decode straight from the state register so an asynchronous reset
  // drops mag_on without waiting for a clock.
  assign bus.sel      = sel_cur;
  assign bus.tick_out = gate_pulse;
  assign bus.load_en  = (state_q == IDLE);
  assign bus.mag_on   = (state_q == COOK);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_mux_sel_controller.sv
// tb_mux_sel_controller: directed bench for mux_sel_controller with default
// parameters (GUARD_CYCLES=4, DONE_CYCLES=8, WDOG_CYCLES=200). The watchdog
// section follows TICK_WATCHDOG_EN.
module tb_mux_sel_controller;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  mux_sel_controller_if bus ();

  mux_sel_controller #(
    .GUARD_CYCLES (4),
    .DONE_CYCLES  (8),
    .WDOG_CYCLES  (200)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start_to_cook();
    bus.startn = 1'b0;
    step(1);
    bus.startn = 1'b1;
    step(5);
  endtask

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk           = 0;
    n_bad           = 0;
    rst_n           = 1'b0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.clearn      = 1'b1;
    bus.door_closed = 1'b1;
    bus.timer_zero  = 1'b0;
    bus.delay_in    = 1'b1;
    bus.divide_in   = 1'b0;

    step(1);
    chk("rst_sel", bus.sel, 0);
    chk("rst_load", bus.load_en, 1);
    chk("rst_mag", bus.mag_on, 0);
    chk("rst_tick", bus.tick_out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_fault", bus.fault, 0);
    step(1);
    rst_n = 1'b1;

    // delay_in high at release must not tick
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk("rel_tick", bus.tick_out, 0);
    end
    chk("rel_sel", bus.sel, 0);

    // three entry pulses, each ticking one clock after its edge
    for (int i = 0; i < 3; i++) begin
      bus.delay_in = 1'b0;
      step(1);
      chk("dly_low", bus.tick_out, 0);
      bus.delay_in = 1'b1;
      step(1);
      chk("dly_tick", bus.tick_out, 1);
      step(1);
      chk("dly_after", bus.tick_out, 0);
    end

    // start -> ARM, edge inside guard dropped, COOK after guard
    bus.startn = 1'b0;
    step(1);
    bus.startn = 1'b1;
    chk("arm_sel", bus.sel, 1);
    chk("arm_load", bus.load_en, 0);
    chk("arm_mag", bus.mag_on, 0);
    bus.divide_in = 1'b1;
    step(1);
    chk("grd_tick", bus.tick_out, 0);
    bus.divide_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("grd_quiet", bus.tick_out, 0);
    end
    chk("arm_hold_mag", bus.mag_on, 0);
    step(1);
    chk("cook_mag", bus.mag_on, 1);
    bus.divide_in = 1'b1;
    step(1);
    chk("cook_tick", bus.tick_out, 1);
    step(1);
    chk("cook_tick_once", bus.tick_out, 0);
    bus.divide_in = 1'b0;
    step(1);

    // door opens -> PAUSE, ticks stop; close + start -> ARM -> COOK
    bus.door_closed = 1'b0;
    step(1);
    chk("pause_mag", bus.mag_on, 0);
    chk("pause_sel", bus.sel, 1);
    bus.divide_in = 1'b1;
    step(1);
    chk("pause_tick", bus.tick_out, 0);
    bus.divide_in = 1'b0;
    step(1);
    bus.door_closed = 1'b1;
    bus.startn      = 1'b0;
    step(1);
    bus.startn = 1'b1;
    chk("rearm_mag", bus.mag_on, 0);
    bus.divide_in = 1'b1;
    step(1);
    chk("rearm_tick", bus.tick_out, 0);
    bus.divide_in = 1'b0;
    step(3);
    chk("rearm_hold_mag", bus.mag_on, 0);
    step(1);
    chk("recook_mag", bus.mag_on, 1);

    // zero with door opening together -> DONE for 8 cycles
    bus.timer_zero  = 1'b1;
    bus.door_closed = 1'b0;
    step(1);
    bus.timer_zero  = 1'b0;
    bus.door_closed = 1'b1;
    chk("done_set", bus.done, 1);
    chk("done_sel", bus.sel, 0);
    chk("done_mag", bus.mag_on, 0);
    step(7);
    chk("done_last", bus.done, 1);
    step(1);
    chk("done_end", bus.done, 0);
    chk("done_idle_load", bus.load_en, 1);

    // DONE cut short by clear in its third cycle
    press_start_to_cook();
    chk("cook2_mag", bus.mag_on, 1);
    bus.timer_zero = 1'b1;
    step(1);
    bus.timer_zero = 1'b0;
    chk("done2_set", bus.done, 1);
    step(2);
    chk("done2_c3", bus.done, 1);
    bus.clearn = 1'b0;
    step(1);
    bus.clearn = 1'b1;
    chk("clr_done", bus.done, 0);
    chk("clr_load", bus.load_en, 1);

    // start with timer at zero stays IDLE
    bus.timer_zero = 1'b1;
    bus.startn     = 1'b0;
    step(1);
    bus.startn     = 1'b1;
    bus.timer_zero = 1'b0;
    chk("tz_sel", bus.sel, 0);
    chk("tz_load", bus.load_en, 1);
    step(1);

    // stop and start together in COOK -> PAUSE; held start never re-arms
    press_start_to_cook();
    chk("cook3_mag", bus.mag_on, 1);
    bus.stopn  = 1'b0;
    bus.startn = 1'b0;
    step(1);
    chk("ss_mag", bus.mag_on, 0);
    chk("ss_sel", bus.sel, 1);
    step(6);
    chk("ss_held_mag", bus.mag_on, 0);
    bus.stopn  = 1'b1;
    bus.startn = 1'b1;
    step(1);

    // asynchronous reset mid-cook
    press_start_to_cook();
    chk("cook4_mag", bus.mag_on, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mag", bus.mag_on, 0);
    chk("arst_sel", bus.sel, 0);
    chk("arst_load", bus.load_en, 1);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_load", bus.load_en, 1);

    // divide_in lost while cooking
    press_start_to_cook();
    chk("cook5_mag", bus.mag_on, 1);
`ifdef TICK_WATCHDOG_EN
    step(199);
    chk("wd_pre_fault", bus.fault, 0);
    chk("wd_pre_mag", bus.mag_on, 1);
    step(1);
    chk("wd_fault", bus.fault, 1);
    chk("wd_mag", bus.mag_on, 0);
    chk("wd_sel", bus.sel, 1);
    bus.startn = 1'b0;
    step(1);
    bus.startn = 1'b1;
    step(6);
    chk("wd_ign_mag", bus.mag_on, 0);
    chk("wd_ign_fault", bus.fault, 1);
    bus.clearn = 1'b0;
    step(1);
    bus.clearn = 1'b1;
    chk("wd_clr_fault", bus.fault, 0);
    chk("wd_clr_load", bus.load_en, 1);
    chk("wd_clr_sel", bus.sel, 0);
`else
    step(205);
    chk("nowd_mag", bus.mag_on, 1);
    chk("nowd_fault", bus.fault, 0);
    bus.clearn = 1'b0;
    step(1);
    bus.clearn = 1'b1;
    chk("cook_clr_load", bus.load_en, 1);
    chk("cook_clr_mag", bus.mag_on, 0);
    chk("cook_clr_sel", bus.sel, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
